rf_sequencer: RTL and testbench

Multi-cycle instruction sequencer that drives the 8×8-bit register file (two asynchronous read ports, one synchronous write port). It accepts one 16-bit instruction at a time over a valid/ready handshake. It reads the source registers, executes an 8-bit ALU operation and writes the result back. It sits between the instruction source (fetch logic or testbench) and the register file, and is the only agent driving the file's write port.

---
 rtl/rf_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_rf_sequencer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_sequencer.sv
// rf_sequencer
//
// Multi-cycle sequencer that drives an 8x8-bit register file. The register
// file has two asynchronous read ports and one synchronous write port. Each
// 16-bit instruction goes through four states: IDLE -> READ -> EXEC -> WB.
// Throughput is one instruction every four cycles.
//
// Instruction word: op=[15:13] rd=[12:10] rs1=[9:7] rs2=[6:4] imm8=[7:0]
//
// Parameters:
//   R0_READONLY   1: writes to r0 are suppressed (result/flags still update)
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   instr_valid/instr/instr_ready instruction handshake (ready only in IDLE)
//   rf_read_reg1/2                read addresses (rs1/rs2 of latched instr)
//   rf_read_data1/2               read data, combinational from the file
//   rf_reg_write/rf_write_reg/rf_write_data  write port, valid in WB only
//   done                          one-cycle pulse when an instruction retires
//   result, flag_z, flag_c        last ALU result and its flags
//   busy                          high in any state other than IDLE
module rf_sequencer #(
  parameter bit R0_READONLY = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  input  logic [15:0] instr,
  output logic        instr_ready,
  output logic [2:0]  rf_read_reg1,
  output logic [2:0]  rf_read_reg2,
  input  logic [7:0]  rf_read_data1,
  input  logic [7:0]  rf_read_data2,
  output logic        rf_reg_write,
  output logic [2:0]  rf_write_reg,
  output logic [7:0]  rf_write_data,
  output logic        done,
  output logic [7:0]  result,
  output logic        flag_z,
  output logic        flag_c,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_t;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_LI  = 3'b110;
  localparam logic [2:0] OP_MOV = 3'b111;

  state_t      state_q, state_d;
  logic [15:0] instr_q, instr_d;
  logic [7:0]  op_a_q, op_a_d;
  logic [7:0]  op_b_q, op_b_d;
  logic [7:0]  result_q, result_d;
  logic        flag_z_q, flag_z_d;
  logic        flag_c_q, flag_c_d;
  logic        done_q, done_d;
  logic        we_q, we_d;
  logic [2:0]  wreg_q, wreg_d;
  logic [7:0]  wdata_q, wdata_d;

  logic [2:0]  op;
  logic [2:0]  rd;
  logic [8:0]  alu;

  assign op = instr_q[15:13];
  assign rd = instr_q[12:10];

  // 9-bit ALU. Bit 8 is the carry for ADD and the borrow for SUB. It is
  // zero for every other op because the operands are zero-extended.
  always_comb begin
    alu = 9'd0;
    case (op)
      OP_ADD:  alu = {1'b0, op_a_q} + {1'b0, op_b_q};
      OP_SUB:  alu = {1'b0, op_a_q} - {1'b0, op_b_q};
      OP_AND:  alu = {1'b0, op_a_q & op_b_q};
      OP_OR:   alu = {1'b0, op_a_q | op_b_q};
      OP_XOR:  alu = {1'b0, op_a_q ^ op_b_q};
      OP_LI:   alu = {1'b0, instr_q[7:0]};
      OP_MOV:  alu = {1'b0, op_a_q};
      default: alu = 9'd0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    result_d = result_q;
    flag_z_d = flag_z_q;
    flag_c_d = flag_c_q;
    wreg_d   = wreg_q;
    wdata_d  = wdata_q;
    done_d   = 1'b0;
    we_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (instr_valid) begin
          instr_d = instr;
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        op_a_d  = rf_read_data1;
        op_b_d  = rf_read_data2;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        // The write-port outputs are loaded here, so they become valid
        // together with the WB state.
        if (op != OP_NOP) begin
          result_d = alu[7:0];
          flag_z_d = (alu[7:0] == 8'h00);
          flag_c_d = alu[8];
          wdata_d  = alu[7:0];
          we_d     = !(R0_READONLY && (rd == 3'd0));
        end else begin
          wdata_d  = result_q;
        end
        wreg_d  = rd;
        done_d  = 1'b1;
        state_d = ST_WB;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      instr_q  <= 16'h0000;
      op_a_q   <= 8'h00;
      op_b_q   <= 8'h00;
      result_q <= 8'h00;
      flag_z_q <= 1'b0;
      flag_c_q <= 1'b0;
      done_q   <= 1'b0;
      we_q     <= 1'b0;
      wreg_q   <= 3'd0;
      wdata_q  <= 8'h00;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      result_q <= result_d;
      flag_z_q <= flag_z_d;
      flag_c_q <= flag_c_d;
      done_q   <= done_d;
      we_q     <= we_d;
      wreg_q   <= wreg_d;
      wdata_q  <= wdata_d;
    end
  end

  // The read addresses come directly from the latched instruction. They
  // stay stable for as long as that instruction is held.
  assign rf_read_reg1  = instr_q[9:7];
  assign rf_read_reg2  = instr_q[6:4];
  assign instr_ready   = (state_q == ST_IDLE);
  assign busy          = (state_q != ST_IDLE);
  assign done          = done_q;
  assign rf_reg_write  = we_q;
  assign rf_write_reg  = wreg_q;
  assign rf_write_data = wdata_q;
  assign result        = result_q;
  assign flag_z        = flag_z_q;
  assign flag_c        = flag_c_q;

endmodule

// File: tb/tb_rf_sequencer.sv
module tb_rf_sequencer;

  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic [2:0]  rf_read_reg1, rf_read_reg2;
  logic [7:0]  rf_read_data1, rf_read_data2;
  logic        rf_reg_write;
  logic [2:0]  rf_write_reg;
  logic [7:0]  rf_write_data;
  logic        done;
  logic [7:0]  result;
  logic        flag_z, flag_c, busy;

  // second instance with writable r0
  logic        instr_valid_b;
  logic [15:0] instr_b;
  logic        instr_ready_b;
  logic [2:0]  rf_read_reg1_b, rf_read_reg2_b;
  logic [7:0]  rf_read_data1_b, rf_read_data2_b;
  logic        rf_reg_write_b;
  logic [2:0]  rf_write_reg_b;
  logic [7:0]  rf_write_data_b;
  logic        done_b;
  logic [7:0]  result_b;
  logic        flag_z_b, flag_c_b, busy_b;

  logic [7:0] rf   [8];
  logic [7:0] rf_b [8];

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int txn = 0;

  typedef struct {
    logic       we;
    logic [2:0] wreg;
    logic [7:0] res;
    logic       z;
    logic       c;
  } exp_t;

  exp_t exp_q[$];
  int   acc_q[$];

  rf_sequencer #(.R0_READONLY(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
    .rf_read_reg1(rf_read_reg1), .rf_read_reg2(rf_read_reg2),
    .rf_read_data1(rf_read_data1), .rf_read_data2(rf_read_data2),
    .rf_reg_write(rf_reg_write), .rf_write_reg(rf_write_reg),
    .rf_write_data(rf_write_data), .done(done), .result(result),
    .flag_z(flag_z), .flag_c(flag_c), .busy(busy)
  );

  rf_sequencer #(.R0_READONLY(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid_b), .instr(instr_b), .instr_ready(instr_ready_b),
    .rf_read_reg1(rf_read_reg1_b), .rf_read_reg2(rf_read_reg2_b),
    .rf_read_data1(rf_read_data1_b), .rf_read_data2(rf_read_data2_b),
    .rf_reg_write(rf_reg_write_b), .rf_write_reg(rf_write_reg_b),
    .rf_write_data(rf_write_data_b), .done(done_b), .result(result_b),
    .flag_z(flag_z_b), .flag_c(flag_c_b), .busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Register file models: asynchronous read, synchronous write.
  assign rf_read_data1   = rf[rf_read_reg1];
  assign rf_read_data2   = rf[rf_read_reg2];
  assign rf_read_data1_b = rf_b[rf_read_reg1_b];
  assign rf_read_data2_b = rf_b[rf_read_reg2_b];
  always @(posedge clk) if (rf_reg_write) rf[rf_write_reg] <= rf_write_data;
  always @(posedge clk) if (rf_reg_write_b) rf_b[rf_write_reg_b] <= rf_write_data_b;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: records accepts and checks each retirement against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (instr_valid && instr_ready) acc_q.push_back(cyc);
      check("ready_vs_busy", {15'd0, instr_ready}, {15'd0, ~busy});
      if (rf_reg_write && !done) check("write_outside_wb", 16'd1, 16'd0);
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 16'd1, 16'd0);
        end else begin
          exp_t e;
          int   a;
          e = exp_q.pop_front();
          txn++;
          $display("txn %0d: we=%0b wreg=%0d wdata=0x%02h result=0x%02h z=%0b c=%0b",
                   txn, rf_reg_write, rf_write_reg, rf_write_data, result, flag_z, flag_c);
          check("rf_reg_write", {15'd0, rf_reg_write}, {15'd0, e.we});
          check("rf_write_reg", {13'd0, rf_write_reg}, {13'd0, e.wreg});
          check("rf_write_data", {8'd0, rf_write_data}, {8'd0, e.res});
          check("result", {8'd0, result}, {8'd0, e.res});
          check("flag_z", {15'd0, flag_z}, {15'd0, e.z});
          check("flag_c", {15'd0, flag_c}, {15'd0, e.c});
          if (acc_q.size() == 0) begin
            check("accept_record", 16'd0, 16'd1);
          end else begin
            a = acc_q.pop_front();
            check("done_latency", 16'(cyc - a), 16'd3);
          end
        end
      end
    end
  end

  // Issue one instruction. Expectations are pushed when push=1. keep=1 leaves
  // instr_valid high after the accept, for back-to-back streaming.
  task automatic issue(input logic [15:0] ins, input logic exp_we, input logic [7:0] exp_res,
                       input logic exp_z, input logic exp_c, input bit push, input bit keep,
                       output int acc_cyc);
    bit acc;
    exp_t e;
    acc = 1'b0;
    acc_cyc = -1;
    if (push) begin
      e.we = exp_we; e.wreg = ins[12:10]; e.res = exp_res; e.z = exp_z; e.c = exp_c;
      exp_q.push_back(e);
    end
    instr = ins;
    instr_valid = 1'b1;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      if (instr_ready) begin
        acc = 1'b1;
        acc_cyc = cyc;
      end
    end
    if (!acc) check("accept_timeout", 16'd0, 16'd1);
    @(posedge clk);
    #1;
    if (!keep) instr_valid = 1'b0;
  endtask

  task automatic reset_outputs_check(input string tag);
    check({tag, "_ready"}, {15'd0, instr_ready}, 16'd1);
    check({tag, "_busy"}, {15'd0, busy}, 16'd0);
    check({tag, "_done"}, {15'd0, done}, 16'd0);
    check({tag, "_we"}, {15'd0, rf_reg_write}, 16'd0);
    check({tag, "_wreg"}, {13'd0, rf_write_reg}, 16'd0);
    check({tag, "_wdata"}, {8'd0, rf_write_data}, 16'd0);
    check({tag, "_rreg"}, {10'd0, rf_read_reg1, rf_read_reg2}, 16'd0);
    check({tag, "_result"}, {8'd0, result}, 16'd0);
    check({tag, "_flags"}, {14'd0, flag_z, flag_c}, 16'd0);
  endtask

  initial begin
    int a0, a1, a2, dummy;
    bit seen;
    for (int i = 0; i < 8; i++) begin
      rf[i] = 8'h00;
      rf_b[i] = 8'h00;
    end
    rst_n = 1'b0;
    instr_valid = 1'b0;
    instr = 16'h0000;
    instr_valid_b = 1'b0;
    instr_b = 16'h0000;
    repeat (3) @(negedge clk);
    reset_outputs_check("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // LI r1,0x7F ; LI r2,0x81 ; ADD r3,r1,r2
    issue(16'hC47F, 1'b1, 8'h7F, 1'b0, 1'b0, 1'b1, 1'b0, dummy);
    issue(16'hC881, 1'b1, 8'h81, 1'b0, 1'b0, 1'b1, 1'b0, dummy);
    issue(16'h2CA0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, dummy);
    // SUB r4,r1,r2 ; SUB r5,r2,r1
    issue(16'h50A0, 1'b1, 8'hFE, 1'b0, 1'b1, 1'b1, 1'b0, dummy);
    issue(16'h5510, 1'b1, 8'h02, 1'b0, 1'b0, 1'b1, 1'b0, dummy);
    // LI r0,0x55 with r0 read-only: no write
    issue(16'hC055, 1'b0, 8'h55, 1'b0, 1'b0, 1'b1, 1'b0, dummy);

    // Stream with instr_valid held: AND r3,r1,r2 ; OR r4,r1,r2 ; MOV r5,r2
    issue(16'h6CA0, 1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 1'b1, a0);
    issue(16'h90A0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b1, a1);
    issue(16'hF500, 1'b1, 8'h81, 1'b0, 1'b0, 1'b1, 1'b0, a2);
    check("stream_gap1", 16'(a1 - a0), 16'd4);
    check("stream_gap2", 16'(a2 - a1), 16'd4);

    // ADD r6,r1,r1 interrupted by reset during EXEC
    issue(16'h3890, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b0, dummy);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    reset_outputs_check("midrst");
    acc_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("r6_not_written", {8'd0, rf[6]}, 16'h0000);

    // The same instruction runs normally after reset
    issue(16'h3890, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b1, 1'b0, dummy);
    // XOR r7,r1,r1 then NOP: flags held
    issue(16'hBC90, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, dummy);
    issue(16'h0000, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, dummy);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", 16'(exp_q.size()), 16'd0);
    @(posedge clk);
    #1;
    check("rf_r0", {8'd0, rf[0]}, 16'h0000);
    check("rf_r1", {8'd0, rf[1]}, 16'h007F);
    check("rf_r3", {8'd0, rf[3]}, 16'h0001);
    check("rf_r4", {8'd0, rf[4]}, 16'h00FF);
    check("rf_r5", {8'd0, rf[5]}, 16'h0081);
    check("rf_r6", {8'd0, rf[6]}, 16'h00FE);
    check("rf_r7", {8'd0, rf[7]}, 16'h0000);

    // LI r0,0x55 on the instance with a writable r0
    instr_b = 16'hC055;
    instr_valid_b = 1'b1;
    @(negedge clk);
    check("b_ready", {15'd0, instr_ready_b}, 16'd1);
    @(posedge clk);
    #1;
    instr_valid_b = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (done_b) begin
        seen = 1'b1;
        txn++;
        $display("txn %0d: we=%0b wreg=%0d wdata=0x%02h result=0x%02h (r0 writable)",
                 txn, rf_reg_write_b, rf_write_reg_b, rf_write_data_b, result_b);
        check("b_we", {15'd0, rf_reg_write_b}, 16'd1);
        check("b_wreg", {13'd0, rf_write_reg_b}, 16'd0);
        check("b_wdata", {8'd0, rf_write_data_b}, 16'h0055);
      end
    end
    if (!seen) check("b_done_timeout", 16'd0, 16'd1);
    @(posedge clk);
    #1;
    check("b_rf_r0", {8'd0, rf_b[0]}, 16'h0055);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
